// File: rtl/img_search_pkg.sv
// Shared types and sizes for the template capture/search path.
// Grid geometry, datapath widths and the capture FSM states.
package img_search_pkg;

  localparam int GRID = 16;
  localparam int ACC_W = 18;
  localparam int PIX_W = 10;
  localparam int COORD_W = 13;
  localparam int CELLS = GRID * GRID;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int GW = $clog2(GRID);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } capState_t;

endpackage

// File: rtl/img_template_capture_if.sv
// Pixel stream, control, read port and status of the capture block.
// master drives the stream, slave is the capture block.
interface img_template_capture_if;
  import img_search_pkg::*;

  logic               iSTART;
  logic               iDVAL;
  logic [COORD_W-1:0] iX;
  logic [COORD_W-1:0] iY;
  logic [PIX_W-1:0]   iDATA;
  logic [COORD_W-1:0] iRD_X;
  logic [COORD_W-1:0] iRD_Y;
  logic [PIX_W-1:0]   oVAL;
  logic               oBUSY;
  logic               oDONE;

  modport master (
    output iSTART, iDVAL, iX, iY, iDATA,
    output iRD_X, iRD_Y,
    input  oVAL, oBUSY, oDONE
  );

  modport slave (
    input  iSTART, iDVAL, iX, iY, iDATA,
    input  iRD_X, iRD_Y,
    output oVAL, oBUSY, oDONE
  );

endinterface

// File: rtl/img_template_capture_ram.sv
// 256x10 simple dual-port template store, registered read.
// Read and write in one block so a same-address access sees old data.
module template_ram
  import img_search_pkg::*;
(
  input  logic              iCLK,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [PIX_W-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [PIX_W-1:0]  rdData
);

  logic [PIX_W-1:0] mem [CELLS];

  // write port plus registered read-before-write read port
  always_ff @(posedge iCLK) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/img_template_capture.sv
// Captures block means of the top-left window into the template RAM.
// Line accumulators sum one cell per column; the last pixel writes.
module img_template_capture
  import img_search_pkg::*;
#(
  parameter int HALVING = 4
) (
  input logic iCLK,
  input logic iRST,
  img_template_capture_if.slave bus
);

  localparam logic [COORD_W-1:0] SUB_MASK =
    COORD_W'((1 << HALVING) - 1);

  capState_t state;
  capState_t nextState;

  logic [ACC_W-1:0] acc [GRID];

  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
  logic [COORD_W-1:0] sx;
  logic [COORD_W-1:0] sy;
  logic               inWin;
  logic               firstPix;
  logic               lastPix;
  logic               lastCell;
  logic               frameOrigin;
  logic               accept;
  logic [GW-1:0]      col;
  logic [GW-1:0]      row;
  logic [ACC_W-1:0]   sum;

  logic               wrEn;
  logic [ADDR_W-1:0]  wrAddr;
  logic [PIX_W-1:0]   wrData;

  logic [COORD_W-1:0] rdCx;
  logic [COORD_W-1:0] rdCy;
  logic               rdOob;
  logic [ADDR_W-1:0]  rdAddr;
  logic [PIX_W-1:0]   ramData;
  logic               zeroQ;

  assign cx = bus.iX >> HALVING;
  assign cy = bus.iY >> HALVING;
  assign sx = bus.iX & SUB_MASK;
  assign sy = bus.iY & SUB_MASK;
  assign col = cx[GW-1:0];
  assign row = cy[GW-1:0];

  assign inWin = bus.iDVAL
    && (cx[COORD_W-1:GW] == '0)
    && (cy[COORD_W-1:GW] == '0);

  assign firstPix = (sx == '0) && (sy == '0);
  assign lastPix = (sx == SUB_MASK) && (sy == SUB_MASK);
  assign lastCell = lastPix && (&col) && (&row);
  assign frameOrigin = (bus.iX == '0) && (bus.iY == '0);

  // a start pulse always wins over a pixel in the same cycle
  assign accept = inWin && !bus.iSTART
    && ((state == CAPTURE)
      || ((state == WAIT_FRAME) && frameOrigin));

  // state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // next-state decode
  always_comb begin
    nextState = state;
    if (bus.iSTART) begin
      nextState = WAIT_FRAME;
    end else begin
      unique case (state)
        WAIT_FRAME: begin
          if (accept) begin
            nextState = CAPTURE;
          end
        end
        CAPTURE: begin
          if (accept && lastCell) begin
            nextState = DONE;
          end
        end
        default: nextState = state;
      endcase
    end
  end

  // status outputs from the current state
  always_comb begin
    bus.oBUSY = (state == WAIT_FRAME)
      || (state == CAPTURE);
    bus.oDONE = (state == DONE);
  end

  // per-column running sum of the cell being scanned
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < GRID; i++) begin
        acc[i] <= '0;
      end
    end else if (accept) begin
      if (firstPix) begin
        acc[col] <= ACC_W'(bus.iDATA);
      end else begin
        acc[col] <= sum;
      end
    end
  end

  assign sum = acc[col] + ACC_W'(bus.iDATA);

  assign wrEn = accept && lastPix;
  assign wrAddr = {row, col};
  assign wrData = PIX_W'(sum >> (2 * HALVING));

  assign rdCx = bus.iRD_X >> HALVING;
  assign rdCy = bus.iRD_Y >> HALVING;
  assign rdOob = (rdCx[COORD_W-1:GW] != '0)
    || (rdCy[COORD_W-1:GW] != '0);
  assign rdAddr = {rdCy[GW-1:0], rdCx[GW-1:0]};

  template_ram uRam (
    .iCLK   (iCLK),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr (rdAddr),
    .rdData (ramData)
  );

  // out-of-range reads and reset force a zero output
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      zeroQ <= 1'b1;
    end else begin
      zeroQ <= rdOob;
    end
  end

  assign bus.oVAL = zeroQ ? '0 : ramData;

endmodule

// File: tb/tb_img_template_capture.sv
// Randomized bench for img_template_capture with a cell-level model.
// Runs a reduced window (HALVING=2) so several frames fit the budget.
module tb_img_template_capture;
  import img_search_pkg::*;

  localparam int H = 2;
  localparam int CS = 1 << H;
  localparam int WIN = 16 * CS;
  localparam int FW = WIN + 4;
  localparam int FH = WIN + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  img_template_capture_if bus ();

  img_template_capture #(
    .HALVING (H)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 armed, 2 capturing, 3 complete
  int mState = 0;
  int mMem [256];
  bit mKnown [256];
  int mSum [256];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
        name, act, exp);
    end
  endtask

  task automatic step();
    int x, y, cx, cy, rx, ry, c, expVal;
    bit expKnown;
    @(posedge clk);
    rx = int'(bus.iRD_X) >> H;
    ry = int'(bus.iRD_Y) >> H;
    expVal = 0;
    expKnown = 1'b1;
    if (rst) begin
      mState = 0;
    end else begin
      if (rx < 16 && ry < 16) begin
        expVal = mMem[ry * 16 + rx];
        expKnown = mKnown[ry * 16 + rx];
      end
      if (bus.iSTART) begin
        mState = 1;
      end else begin
        x = int'(bus.iX);
        y = int'(bus.iY);
        cx = x / CS;
        cy = y / CS;
        if (bus.iDVAL && cx < 16 && cy < 16
          && (mState == 2
            || (mState == 1 && x == 0 && y == 0))) begin
          mState = 2;
          c = cy * 16 + cx;
          if (x % CS == 0 && y % CS == 0)
            mSum[c] = int'(bus.iDATA);
          else
            mSum[c] += int'(bus.iDATA);
          if (x % CS == CS - 1 && y % CS == CS - 1) begin
            mMem[c] = mSum[c] / (CS * CS);
            mKnown[c] = 1'b1;
            if (c == 255) mState = 3;
          end
        end
      end
    end
    #1;
    if (expKnown) chk("oVAL", int'(bus.oVAL), expVal);
    chk("oBUSY", int'(bus.oBUSY),
      int'(mState == 1 || mState == 2));
    chk("oDONE", int'(bus.oDONE), int'(mState == 3));
  endtask

  task automatic randRead();
    bus.iRD_X = 13'($urandom_range(WIN + 16));
    bus.iRD_Y = 13'($urandom_range(WIN + 16));
  endtask

  task automatic idle(int n);
    bus.iDVAL = 1'b0;
    for (int i = 0; i < n; i++) begin
      randRead();
      step();
    end
  endtask

  task automatic pulseStart();
    bus.iDVAL = 1'b0;
    bus.iSTART = 1'b1;
    step();
    bus.iSTART = 1'b0;
  endtask

  task automatic readAt(string name, int x, int y, int exp);
    bus.iDVAL = 1'b0;
    bus.iRD_X = 13'(x);
    bus.iRD_Y = 13'(y);
    step();
    chk(name, int'(bus.oVAL), exp);
  endtask

  function automatic int pixVal(int kind, int x, int y);
    int v;
    unique case (kind)
      0: v = 512;
      1: begin
        if (x < CS && y < CS)
          v = ((x + y) % 2 == 1) ? 1023 : 0;
        else
          v = ((x / CS) * 60 + (y / CS)) % 1024;
      end
      2: v = (x < WIN && y < WIN) ? 100 : 1023;
      default: v = int'($urandom_range(1023));
    endcase
    return v;
  endfunction

  task automatic frame(int kind, int gap, int startY,
    int rstY, int rwX, int rwY, int rwOld);
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        while (int'($urandom_range(99)) < gap) begin
          bus.iDVAL = 1'b0;
          randRead();
          step();
        end
        bus.iDVAL = 1'b1;
        bus.iX = 13'(x);
        bus.iY = 13'(y);
        bus.iDATA = 10'(pixVal(kind, x, y));
        bus.iSTART = (y == startY && x == 0);
        rst = (y == rstY && x == 0);
        if (x == rwX && y == rwY) begin
          bus.iRD_X = 13'(x);
          bus.iRD_Y = 13'(y);
        end else begin
          randRead();
        end
        step();
        if (x == rwX && y == rwY)
          chk("rw_same_cycle", int'(bus.oVAL), rwOld);
        if (y == rstY && x == 0) begin
          chk("rst_busy", int'(bus.oBUSY), 0);
          chk("rst_done", int'(bus.oDONE), 0);
          chk("rst_val", int'(bus.oVAL), 0);
        end
        bus.iSTART = 1'b0;
        rst = 1'b0;
      end
    end
    bus.iDVAL = 1'b0;
  endtask

  task automatic sweep(int expConst);
    bus.iDVAL = 1'b0;
    for (int c = 0; c < 256; c++) begin
      bus.iRD_X = 13'((c % 16) * CS
        + int'($urandom_range(CS - 1)));
      bus.iRD_Y = 13'((c / 16) * CS
        + int'($urandom_range(CS - 1)));
      step();
      if (expConst >= 0)
        chk("sweep", int'(bus.oVAL), expConst);
    end
  endtask

  initial begin
    bus.iSTART = 1'b0;
    bus.iDVAL = 1'b0;
    bus.iX = '0;
    bus.iY = '0;
    bus.iDATA = '0;
    bus.iRD_X = '0;
    bus.iRD_Y = '0;
    rst = 1'b1;

    bus.iSTART = 1'b1;
    bus.iDVAL = 1'b1;
    idle(3);
    bus.iSTART = 1'b0;
    chk("reset_val", int'(bus.oVAL), 0);
    chk("reset_busy", int'(bus.oBUSY), 0);
    chk("reset_done", int'(bus.oDONE), 0);
    rst = 1'b0;
    readAt("oob_read_idle", 300, 10, 0);

    // constant frame
    pulseStart();
    chk("busy_after_start", int'(bus.oBUSY), 1);
    frame(0, 0, -1, -1, -1, -1, 0);
    idle(2);
    chk("const_done", int'(bus.oDONE), 1);
    chk("const_busy", int'(bus.oBUSY), 0);
    sweep(512);
    readAt("read_17_33", 17, 33, 512);
    readAt("oob_read_x", 300, 10, 0);
    readAt("oob_read_y", 10, 300, 0);

    // averaging with a same-cycle read/write of cell (2,3)
    pulseStart();
    frame(1, 0, -1, -1, 2 * CS + CS - 1,
      3 * CS + CS - 1, 512);
    idle(2);
    chk("avg_done", int'(bus.oDONE), 1);
    sweep(-1);
    readAt("avg_cell00", 1, 2, 511);
    readAt("avg_cell35", 3 * CS + 1, 5 * CS + 2, 185);
    readAt("avg_cell23", 2 * CS, 3 * CS, 123);

    // window clipping with valid gaps
    pulseStart();
    frame(2, 30, -1, -1, -1, -1, 0);
    idle(2);
    chk("clip_done", int'(bus.oDONE), 1);
    sweep(100);

    // restart mid-frame
    pulseStart();
    frame(3, 0, FH / 3, -1, -1, -1, 0);
    idle(2);
    chk("restart_no_done", int'(bus.oDONE), 0);
    chk("restart_busy", int'(bus.oBUSY), 1);
    frame(3, 10, -1, -1, -1, -1, 0);
    idle(2);
    chk("restart_done", int'(bus.oDONE), 1);
    sweep(-1);

    // reset mid-capture, then an ignored frame
    pulseStart();
    frame(3, 0, -1, FH / 5, -1, -1, 0);
    chk("after_rst_busy", int'(bus.oBUSY), 0);
    frame(3, 0, -1, -1, -1, -1, 0);
    chk("ignored_busy", int'(bus.oBUSY), 0);
    chk("ignored_done", int'(bus.oDONE), 0);
    sweep(-1);
    pulseStart();
    frame(0, 5, -1, -1, -1, -1, 0);
    idle(2);
    chk("final_done", int'(bus.oDONE), 1);
    readAt("final_17_33", 17, 33, 512);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
